// File: rtl/cam_pkg.sv
// Shared FSM state type and decimation encoding for the DVP camera capture block.
// dec_mask() turns the log2 decimation code into the low-bit mask a kept coordinate must clear.
package cam_pkg;

    localparam int DEC_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } cam_state_e;

    localparam logic [DEC_W-1:0] DEC_1 = 2'd0;
    localparam logic [DEC_W-1:0] DEC_2 = 2'd1;
    localparam logic [DEC_W-1:0] DEC_4 = 2'd2;
    localparam logic [DEC_W-1:0] DEC_8 = 2'd3;

    function automatic logic [15:0] dec_mask(input logic [DEC_W-1:0] dec);
        logic [15:0] m;
        case (dec)
            DEC_1:   m = 16'h0000;
            DEC_2:   m = 16'h0001;
            DEC_4:   m = 16'h0003;
            DEC_8:   m = 16'h0007;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Byte-phase counter and assembly register: gathers BYTES_PER_PIX camera bytes into one pixel.
// The pixel output includes the byte currently on the bus, so pix_done marks a complete pixel.
module cam_pix_pack #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter bit BYTE_SWAP     = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            en,
    input  logic [DATA_W-1:0]               byte_in,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix,
    output logic                            pix_done,
    output logic                            partial
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    localparam int PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BYTES_PER_PIX - 1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PIX_W-1:0] acc_q, acc_d;
    int               lane;

    always_comb begin
        // Byte lane for this phase: first byte lands MS-first unless swapped.
        lane = BYTE_SWAP ? int'(phase_q) : (BYTES_PER_PIX - 1 - int'(phase_q));
        pix  = acc_q;
        for (int i = 0; i < BYTES_PER_PIX; i++) begin
            if (i == lane) begin
                pix[i*DATA_W +: DATA_W] = byte_in;
            end
        end
        pix_done = en && (phase_q == PH_LAST);
        partial  = (phase_q != '0);

        phase_d = phase_q;
        acc_d   = acc_q;
        if (clr) begin
            phase_d = '0;
            acc_d   = '0;
        end else if (en) begin
            acc_d   = pix;
            phase_d = pix_done ? '0 : (phase_q + PH_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            acc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/cam_capture_param.sv
// DVP camera capture: assembles byte-serial pixels, applies a crop window and power-of-two
// decimation, and feeds kept pixels with X/Y/frame counters to the SDRAM write FIFO.
module cam_capture_param
    import cam_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter bit BYTE_SWAP     = 1'b0,
    parameter int X_W           = 11,
    parameter int Y_W           = 10,
    parameter int FCNT_W        = 32,
    parameter bit FVAL_POL      = 1'b1
) (
    input  logic                            iCLK,
    input  logic                            iRST,
    input  logic [DATA_W-1:0]               iDATA,
    input  logic                            iFVAL,
    input  logic                            iLVAL,
    input  logic                            iSTART,
    input  logic                            iEND,
    input  logic [X_W-1:0]                  iWIN_X0,
    input  logic [Y_W-1:0]                  iWIN_Y0,
    input  logic [X_W-1:0]                  iWIN_W,
    input  logic [Y_W-1:0]                  iWIN_H,
    input  logic [DEC_W-1:0]                iDEC,
    output logic [DATA_W*BYTES_PER_PIX-1:0] oDATA,
    output logic                            oDVAL,
    output logic [X_W-1:0]                  oX_Cont,
    output logic [Y_W-1:0]                  oY_Cont,
    output logic [FCNT_W-1:0]               oFrame_Cont,
    output logic                            oSOF,
    output logic                            oLINE_ERR,
    output logic                            oBUSY
);

    // state       | meaning
    // ST_IDLE     | not capturing; waits for iSTART
    // ST_WAIT_SOF | armed; waits for the next frame-valid rising edge
    // ST_ACTIVE   | capturing frames until a pending stop meets end of frame

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;

    cam_state_e        state_q, state_d;
    logic              stop_req_q, stop_req_d;
    logic              fv, fv_q, lval_q;
    logic              sof, eof, line_end, byte_en, pack_clr, frame_start;

    logic [X_W-1:0]    x_q, x_d;
    logic              x_ovf_q, x_ovf_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              line_has_q, line_has_d;
    logic              frame_kept_q, frame_kept_d;
    logic              sof_pend_q, sof_pend_d;

    logic [X_W-1:0]    win_x0_q, win_x0_d, win_w_q, win_w_d;
    logic [Y_W-1:0]    win_y0_q, win_y0_d, win_h_q, win_h_d;
    logic [DEC_W-1:0]  dec_q, dec_d;

    logic [PIX_W-1:0]  data_q, data_d;
    logic              dval_q, dval_d;
    logic [X_W-1:0]    xo_q, xo_d;
    logic [Y_W-1:0]    yo_q, yo_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              sof_o_q, sof_o_d;
    logic              lerr_q, lerr_d;
    logic              busy_q, busy_d;

    logic [PIX_W-1:0]  pix;
    logic              pix_done, partial;
    logic [X_W-1:0]    x_mask;
    logic [Y_W-1:0]    y_mask;
    logic              in_x, in_y, dec_ok, keep;

    cam_pix_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .BYTE_SWAP     (BYTE_SWAP)
    ) u_pix_pack (
        .clk      (iCLK),
        .rst      (iRST),
        .clr      (pack_clr),
        .en       (byte_en),
        .byte_in  (iDATA),
        .pix      (pix),
        .pix_done (pix_done),
        .partial  (partial)
    );

    always_comb begin
        fv       = (iFVAL == FVAL_POL);
        sof      = fv && !fv_q;
        eof      = !fv && fv_q;
        line_end = lval_q && !iLVAL;
        byte_en  = (state_q == ST_ACTIVE) && iLVAL && fv;
        pack_clr = !iLVAL || (state_q != ST_ACTIVE);

        // Window bounds are compared one bit wider so X0+W never wraps.
        x_mask = X_W'(dec_mask(dec_q));
        y_mask = Y_W'(dec_mask(dec_q));
        in_x   = (win_w_q == '0) ||
                 (({1'b0, x_q} >= {1'b0, win_x0_q}) &&
                  ({1'b0, x_q} <  ({1'b0, win_x0_q} + {1'b0, win_w_q})));
        in_y   = (win_h_q == '0) ||
                 (({1'b0, y_q} >= {1'b0, win_y0_q}) &&
                  ({1'b0, y_q} <  ({1'b0, win_y0_q} + {1'b0, win_h_q})));
        dec_ok = ((x_q & x_mask) == '0) && ((y_q & y_mask) == '0);
        keep   = in_x && in_y && dec_ok && !x_ovf_q;
    end

    always_comb begin
        state_d      = state_q;
        stop_req_d   = stop_req_q;
        x_d          = x_q;
        x_ovf_d      = x_ovf_q;
        y_d          = y_q;
        line_has_d   = line_has_q;
        frame_kept_d = frame_kept_q;
        sof_pend_d   = sof_pend_q;
        win_x0_d     = win_x0_q;
        win_w_d      = win_w_q;
        win_y0_d     = win_y0_q;
        win_h_d      = win_h_q;
        dec_d        = dec_q;
        data_d       = data_q;
        xo_d         = xo_q;
        yo_d         = yo_q;
        fcnt_d       = fcnt_q;
        dval_d       = 1'b0;
        sof_o_d      = 1'b0;
        lerr_d       = 1'b0;
        frame_start  = 1'b0;

        if (state_q == ST_ACTIVE) begin
            if (byte_en) begin
                line_has_d = 1'b1;
            end
            if (pix_done) begin
                if (keep) begin
                    dval_d       = 1'b1;
                    data_d       = pix;
                    xo_d         = x_q;
                    yo_d         = y_q;
                    sof_o_d      = sof_pend_q;
                    sof_pend_d   = 1'b0;
                    frame_kept_d = 1'b1;
                end
                // X sticks at all-ones; anything past that column is dropped.
                if (x_q == '1) begin
                    x_ovf_d = 1'b1;
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            if (line_end) begin
                if (line_has_q) begin
                    y_d = y_q + Y_W'(1);
                end
                line_has_d = 1'b0;
                lerr_d     = partial;
            end
        end

        if (!iLVAL) begin
            x_d     = '0;
            x_ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                stop_req_d = 1'b0;
                if (iSTART && !iEND) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (iEND || stop_req_q) begin
                    state_d    = ST_IDLE;
                    stop_req_d = 1'b0;
                end else if (sof) begin
                    state_d     = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                stop_req_d = stop_req_q || iEND;
                if (sof) begin
                    frame_start = 1'b1;
                end else if (eof) begin
                    if (frame_kept_q) begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                    frame_kept_d = 1'b0;
                    if (stop_req_d) begin
                        state_d    = ST_IDLE;
                        stop_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                stop_req_d = 1'b0;
            end
        endcase

        if (frame_start) begin
            win_x0_d     = iWIN_X0;
            win_w_d      = iWIN_W;
            win_y0_d     = iWIN_Y0;
            win_h_d      = iWIN_H;
            dec_d        = iDEC;
            x_d          = '0;
            x_ovf_d      = 1'b0;
            y_d          = '0;
            line_has_d   = 1'b0;
            frame_kept_d = 1'b0;
            sof_pend_d   = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= ST_IDLE;
            stop_req_q   <= 1'b0;
            fv_q         <= 1'b0;
            lval_q       <= 1'b0;
            x_q          <= '0;
            x_ovf_q      <= 1'b0;
            y_q          <= '0;
            line_has_q   <= 1'b0;
            frame_kept_q <= 1'b0;
            sof_pend_q   <= 1'b0;
            win_x0_q     <= '0;
            win_w_q      <= '0;
            win_y0_q     <= '0;
            win_h_q      <= '0;
            dec_q        <= '0;
            data_q       <= '0;
            dval_q       <= 1'b0;
            xo_q         <= '0;
            yo_q         <= '0;
            fcnt_q       <= '0;
            sof_o_q      <= 1'b0;
            lerr_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stop_req_q   <= stop_req_d;
            fv_q         <= fv;
            lval_q       <= iLVAL;
            x_q          <= x_d;
            x_ovf_q      <= x_ovf_d;
            y_q          <= y_d;
            line_has_q   <= line_has_d;
            frame_kept_q <= frame_kept_d;
            sof_pend_q   <= sof_pend_d;
            win_x0_q     <= win_x0_d;
            win_w_q      <= win_w_d;
            win_y0_q     <= win_y0_d;
            win_h_q      <= win_h_d;
            dec_q        <= dec_d;
            data_q       <= data_d;
            dval_q       <= dval_d;
            xo_q         <= xo_d;
            yo_q         <= yo_d;
            fcnt_q       <= fcnt_d;
            sof_o_q      <= sof_o_d;
            lerr_q       <= lerr_d;
            busy_q       <= busy_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = xo_q;
    assign oY_Cont     = yo_q;
    assign oFrame_Cont = fcnt_q;
    assign oSOF        = sof_o_q;
    assign oLINE_ERR   = lerr_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_cam_capture_param.sv
// Bench for cam_capture_param: three instances (default, byte-swapped, 1 byte/pixel) share one
// stimulus; a per-instance expected-pixel queue is filled as bytes are driven.
module tb_cam_capture_param;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int FW = 32;
    localparam int NV = 7;

    typedef struct {
        logic [15:0] data;
        int          x;
        int          y;
        logic        sof;
    } pix_t;

    typedef struct {
        int nb; int nl; int x0; int w; int y0; int h; int dec; int exp_dv; int exp_lerr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, fval, lval, start, stop;
    logic [7:0]    din;
    logic [XW-1:0] wx0, ww;
    logic [YW-1:0] wy0, wh;
    logic [1:0]    dec;

    logic [15:0]   a_data, s_data;
    logic [7:0]    b_data;
    logic          a_dval, s_dval, b_dval, a_sof, s_sof, b_sof;
    logic          a_lerr, s_lerr, b_lerr, a_busy, s_busy, b_busy;
    logic [XW-1:0] a_x, s_x, b_x;
    logic [YW-1:0] a_y, s_y, b_y;
    logic [FW-1:0] a_fc, s_fc, b_fc;

    pix_t qa[$], qs[$], qb[$];
    vec_t vt[NV];
    int   pass_cnt = 0, total_cnt = 0;
    int   a_dv_n = 0, a_lerr_n = 0, s_lerr_n = 0, b_lerr_n = 0;
    int   exp_fca = 0, exp_fcb = 0;

    always #5 clk = ~clk;

    cam_capture_param dut_a (
        .iCLK(clk), .iRST(rst), .iDATA(din), .iFVAL(fval), .iLVAL(lval), .iSTART(start), .iEND(stop),
        .iWIN_X0(wx0), .iWIN_Y0(wy0), .iWIN_W(ww), .iWIN_H(wh), .iDEC(dec),
        .oDATA(a_data), .oDVAL(a_dval), .oX_Cont(a_x), .oY_Cont(a_y), .oFrame_Cont(a_fc),
        .oSOF(a_sof), .oLINE_ERR(a_lerr), .oBUSY(a_busy));

    cam_capture_param #(.BYTE_SWAP(1'b1)) dut_s (
        .iCLK(clk), .iRST(rst), .iDATA(din), .iFVAL(fval), .iLVAL(lval), .iSTART(start), .iEND(stop),
        .iWIN_X0(wx0), .iWIN_Y0(wy0), .iWIN_W(ww), .iWIN_H(wh), .iDEC(dec),
        .oDATA(s_data), .oDVAL(s_dval), .oX_Cont(s_x), .oY_Cont(s_y), .oFrame_Cont(s_fc),
        .oSOF(s_sof), .oLINE_ERR(s_lerr), .oBUSY(s_busy));

    cam_capture_param #(.BYTES_PER_PIX(1)) dut_b (
        .iCLK(clk), .iRST(rst), .iDATA(din), .iFVAL(fval), .iLVAL(lval), .iSTART(start), .iEND(stop),
        .iWIN_X0(wx0), .iWIN_Y0(wy0), .iWIN_W(ww), .iWIN_H(wh), .iDEC(dec),
        .oDATA(b_data), .oDVAL(b_dval), .oX_Cont(b_x), .oY_Cont(b_y), .oFrame_Cont(b_fc),
        .oSOF(b_sof), .oLINE_ERR(b_lerr), .oBUSY(b_busy));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cmp_pix(input string name, input pix_t e, input logic [15:0] d,
                           input int x, input int y, input logic sof);
        total_cnt++;
        if (e.data === d && e.x == x && e.y == y && e.sof === sof) pass_cnt++;
        else $display("FAIL %s: got data=%h x=%0d y=%0d sof=%b expected data=%h x=%0d y=%0d sof=%b",
                      name, d, x, y, sof, e.data, e.x, e.y, e.sof);
    endtask

    task automatic unexpected(input string name);
        total_cnt++;
        $display("FAIL %s: got oDVAL=1 expected no pixel pending", name);
    endtask

    task automatic sample();
        pix_t e;
        if (a_dval) begin
            a_dv_n++;
            if (qa.size() == 0) unexpected("a_dval");
            else begin e = qa.pop_front(); cmp_pix("a_pix", e, a_data, int'(a_x), int'(a_y), a_sof); end
        end
        if (s_dval) begin
            if (qs.size() == 0) unexpected("s_dval");
            else begin e = qs.pop_front(); cmp_pix("s_pix", e, s_data, int'(s_x), int'(s_y), s_sof); end
        end
        if (b_dval) begin
            if (qb.size() == 0) unexpected("b_dval");
            else begin e = qb.pop_front(); cmp_pix("b_pix", e, {8'h00, b_data}, int'(b_x), int'(b_y), b_sof); end
        end
        if (a_lerr) a_lerr_n++;
        if (s_lerr) s_lerr_n++;
        if (b_lerr) b_lerr_n++;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic bit keep(input int x, input int y);
        int  m;
        bit  kx, ky;
        m  = (1 << dec) - 1;
        kx = (ww == 0) || (x >= int'(wx0) && x < int'(wx0) + int'(ww));
        ky = (wh == 0) || (y >= int'(wy0) && y < int'(wy0) + int'(wh));
        return kx && ky && ((x & m) == 0) && ((y & m) == 0);
    endfunction

    // p_kind: 0 none, 1 iEND, 2 iSTART, 3 iRST -- pulsed on byte 3 of line p_line
    task automatic frame(input int nb, input int nl, input bit on, input int p_line, input int p_kind);
        int         k;
        logic [7:0] prev;
        bit         fa, fb, pa, pb;
        pix_t       e;
        k = 0; prev = 8'h00; fa = 1'b1; fb = 1'b1; pa = 1'b0; pb = 1'b0;
        step();
        fval = 1'b1;
        repeat (3) step();
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < nb; b++) begin
                step();
                if (p_kind == 3 && l == p_line && b == 4) begin
                    check("rst_dval", a_dval, 0);
                    check("rst_data", a_data, 0);
                    check("rst_busy", a_busy, 0);
                    check("rst_fcnt", a_fc, 0);
                    check("rst_xy", {a_x, a_y}, 0);
                    check("rst_b_dval", b_dval, 0);
                end
                lval = 1'b1;
                din  = 8'((k + 1) * 17);
                k++;
                if (l == p_line && b == 3) begin
                    case (p_kind)
                        1: stop  = 1'b1;
                        2: start = 1'b1;
                        3: begin rst = 1'b1; on = 1'b0; exp_fca = 0; exp_fcb = 0; end
                        default: ;
                    endcase
                end
                if (on) begin
                    if (keep(b, l)) begin
                        e.data = {8'h00, din}; e.x = b; e.y = l; e.sof = fb;
                        qb.push_back(e); fb = 1'b0; pb = 1'b1;
                    end
                    if ((b % 2) == 1 && keep(b / 2, l)) begin
                        e.data = {prev, din}; e.x = b / 2; e.y = l; e.sof = fa;
                        qa.push_back(e);
                        e.data = {din, prev};
                        qs.push_back(e); fa = 1'b0; pa = 1'b1;
                    end
                end
                prev = din;
            end
            step();
            lval = 1'b0;
            repeat (2) step();
        end
        fval = 1'b0;
        repeat (4) step();
        if (on && pa) exp_fca++;
        if (on && pb) exp_fcb++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dv0, le0, ls0, lb0;
        vt[0] = '{8, 2, 0, 0, 0, 0, 0, 8, 0};
        vt[1] = '{32, 8, 4, 4, 2, 3, 0, 12, 0};
        vt[2] = '{32, 8, 0, 0, 0, 0, 1, 32, 0};
        vt[3] = '{7, 2, 0, 0, 0, 0, 0, 6, 2};
        vt[4] = '{8, 2, 10, 4, 0, 0, 0, 0, 0};
        vt[5] = '{32, 8, 0, 0, 0, 0, 2, 8, 0};
        vt[6] = '{32, 8, 0, 0, 6, 5, 0, 32, 0};

        rst = 1'b1; fval = 1'b0; lval = 1'b0; start = 1'b0; stop = 1'b0; din = 8'h00;
        wx0 = '0; ww = '0; wy0 = '0; wh = '0; dec = '0;
        step(); rst = 1'b1;
        step(); rst = 1'b1;
        step();
        check("reset_dval", a_dval, 0);
        check("reset_data", a_data, 0);
        check("reset_x", a_x, 0);
        check("reset_y", a_y, 0);
        check("reset_fcnt", a_fc, 0);
        check("reset_sof", a_sof, 0);
        check("reset_lerr", a_lerr, 0);
        check("reset_busy", a_busy, 0);

        start = 1'b1;
        step();
        check("arm_busy", a_busy, 1);

        for (int i = 0; i < NV; i++) begin
            wx0 = XW'(vt[i].x0); ww = XW'(vt[i].w);
            wy0 = YW'(vt[i].y0); wh = YW'(vt[i].h);
            dec = 2'(vt[i].dec);
            dv0 = a_dv_n; le0 = a_lerr_n; ls0 = s_lerr_n; lb0 = b_lerr_n;
            frame(vt[i].nb, vt[i].nl, 1'b1, -1, 0);
            check($sformatf("v%0d_dval_count", i), a_dv_n - dv0, vt[i].exp_dv);
            check($sformatf("v%0d_line_err", i), a_lerr_n - le0, vt[i].exp_lerr);
            check($sformatf("v%0d_s_line_err", i), s_lerr_n - ls0, vt[i].exp_lerr);
            check($sformatf("v%0d_b_line_err", i), b_lerr_n - lb0, 0);
            check($sformatf("v%0d_fcnt", i), a_fc, exp_fca);
            check($sformatf("v%0d_s_fcnt", i), s_fc, exp_fca);
            check($sformatf("v%0d_b_fcnt", i), b_fc, exp_fcb);
            check($sformatf("v%0d_queues", i), qa.size() + qs.size() + qb.size(), 0);
        end

        wx0 = '0; ww = '0; wy0 = '0; wh = '0; dec = '0;

        // Stop request mid-frame: frame still completes, then capture halts.
        frame(8, 2, 1'b1, 0, 1);
        check("stop_fcnt", a_fc, exp_fca);
        check("stop_busy", a_busy, 0);
        check("stop_s_busy", s_busy, 0);
        dv0 = a_dv_n;
        frame(8, 2, 1'b0, -1, 0);
        check("stopped_no_dval", a_dv_n - dv0, 0);
        check("stopped_fcnt", a_fc, exp_fca);

        start = 1'b1; stop = 1'b1;
        step();
        step();
        check("start_end_idle", a_busy, 0);

        // Arm while a frame is already running: nothing until the next frame start.
        dv0 = a_dv_n;
        frame(8, 2, 1'b0, 0, 2);
        check("rearm_no_dval", a_dv_n - dv0, 0);
        check("rearm_busy", a_busy, 1);
        check("rearm_b_busy", b_busy, 1);
        dv0 = a_dv_n;
        frame(8, 2, 1'b1, -1, 0);
        check("rearm_dval_count", a_dv_n - dv0, 8);
        check("rearm_fcnt", a_fc, exp_fca);

        frame(8, 3, 1'b1, 1, 3);
        check("post_rst_busy", a_busy, 0);
        check("post_rst_fcnt", a_fc, exp_fca);
        check("post_rst_queues", qa.size() + qs.size() + qb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
